alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - RV32I integer ALU for the execute stage: add/sub, AND/OR/XOR, SLL/SRL/SRA, SLT/SLTU.
//  - Decodes ALUOp/funct3/funct7 and registers Result/Zero/Less.
//  - Latency is 1 clock cycle. Datapath feeds writeback and branch compare.
// PARAMETERS
//  - XLEN   32   data width; all arithmetic is modulo 2^XLEN
// PORTS
//  - clk      in   1   rising-edge clock (the only clock)
//  - rst_n    in   1   asynchronous active-low reset
//  - in_valid in   1   operands/controls valid; sample on this edge
//  - A        in   32  operand A / shift source
//  - B        in   32  operand B
//  - ALUOp    in   2   op class: 00 arith, 01 logic, 10 shift, 11 compare
//  - funct3   in   3   op select within class
//  - shamt    in   5   shift amount (shifts ignore B)
//  - funct7   in   7   bit5 selects SUB (class 00) / SRA (class 10)
//  - out_valid out 1   Result/Zero/Less updated this cycle
//  - Result   out 32   registered result
//  - Zero     out 1    registered (Result == 0)
//  - Less     out 1    registered compare flag
// BEHAVIOUR
//  - Reset: asserting rst_n=0 clears Result, Zero, Less and out_valid to 0 immediately.
//    Zero reads 0 during reset, not 1.
//  - Reset mid-operation discards the in-flight result.
//  - Operation only when in_valid=1 at a rising edge:
//    - Outputs load next-state values.
//    - out_valid=1 for exactly the following cycle.
//  - When in_valid=0: Result/Zero/Less hold their values and out_valid=0.
//  - Back-to-back valid inputs give one result per cycle, with no bubbles.
//  - ALUOp=00: funct7[5]=0 -> A+B; funct7[5]=1 -> A-B.
//    Wraps mod 2^32; no carry/overflow output. funct3 ignored.
//  - ALUOp=01, selected by funct3:
//    - 000 -> A&B
//    - 001 -> A|B
//    - 010 -> A^B
//    - other -> 0
//  - ALUOp=10, selected by funct3:
//    - 000 -> A<<shamt
//    - 101 with funct7[5]=0 -> logical A>>shamt
//    - 101 with funct7[5]=1 -> arithmetic A>>>shamt (sign-fill from A[31])
//    - other -> 0
//    - shamt=0 returns A unchanged.
//  - ALUOp=11, selected by funct3:
//    - 010 -> signed A<B
//    - 011 -> unsigned A<B
//    - Result = {31'b0, cmp}; other funct3 -> Result 0, cmp 0.
//  - Zero = (next Result == 32'h0), computed from the same cycle's result.
//  - Less:
//    - ALUOp=11 -> cmp bit.
//    - Otherwise -> signed A<B (usable for branches).
//  - Inputs that are don't-care for the selected op (B on shifts, shamt otherwise)
//    must not affect outputs.
//  - All decode is purely combinational into one register stage; no FSM.
// TESTING (each: drive with in_valid=1, check on the next cycle with out_valid=1)
//  - ADD/SUB:
//    - A=0000000A B=00000014 op00 f7=00 -> Result 0000001E Z0 L1
//    - A=00000014 B=0000000A f7=20 -> 0000000A Z0 L0
//  - Logic, A=0F0F0F0F B=00FF00FF:
//    - f3=000 -> 000F000F
//    - f3=001 -> 0FFF0FFF
//    - f3=010 -> 0FF00FF0
//  - Shifts:
//    - A=1 shamt=5 f3=000 -> 00000020
//    - A=20 shamt=2 f3=101 f7=00 -> 00000008
//    - A=FFFFFFE0 shamt=2 f7=20 -> FFFFFFF8
//  - Compare:
//    - A=1 B=2 f3=010 -> Result 1 L1 Z0
//    - A=FFFFFFFE B=1 f3=011 -> Result 0 L0 Z1
//  - Zero/boundaries:
//    - 0+0 -> Result 0 Z1
//    - FFFFFFFF+1 -> 0 Z1 (wrap)
//    - SRA 80000000 by 31 -> FFFFFFFF
//  - Control:
//    - in_valid=0 -> outputs hold, out_valid=0.
//    - Assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
//    - After release, first valid input -> correct result next cycle.

Source files
------------

// File: rtl/alu.sv
// RV32I integer ALU for the execute stage: combinational decode of ALUOp/funct3/funct7
// into a single register stage holding Result, Zero and Less (1-cycle latency).
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [4:0]      shamt,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Less
);

  // Handshake: valid-only, no backpressure. An operation is accepted on every rising
  // edge where in_valid=1; its result appears with out_valid=1 for exactly the next
  // cycle. With in_valid=0 the result registers hold and out_valid drops to 0.

  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_CMP   = 2'b11;

  logic [XLEN-1:0] result_d, result_q;
  logic            zero_d, zero_q;
  logic            less_d, less_q;
  logic            valid_q;
  logic            cmp;
  logic            signed_lt;
  logic            unsigned_lt;
  logic [XLEN-1:0] sra_res;
  logic            unused_funct7;

  assign signed_lt     = $signed(A) < $signed(B);
  assign unsigned_lt   = A < B;
  assign sra_res       = $unsigned($signed(A) >>> shamt);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    result_d = '0;
    cmp      = 1'b0;
    case (ALUOp)
      OP_ARITH: result_d = funct7[5] ? (A - B) : (A + B);
      OP_LOGIC: begin
        case (funct3)
          3'b000:  result_d = A & B;
          3'b001:  result_d = A | B;
          3'b010:  result_d = A ^ B;
          default: result_d = '0;
        endcase
      end
      OP_SHIFT: begin
        case (funct3)
          3'b000:  result_d = A << shamt;
          3'b101:  result_d = funct7[5] ? sra_res : (A >> shamt);
          default: result_d = '0;
        endcase
      end
      OP_CMP: begin
        case (funct3)
          3'b010:  cmp = signed_lt;
          3'b011:  cmp = unsigned_lt;
          default: cmp = 1'b0;
        endcase
        result_d = {{(XLEN-1){1'b0}}, cmp};
      end
      default: result_d = '0;
    endcase
  end

  // Less follows the compare bit for compares, otherwise signed A<B for branch use.
  assign zero_d = (result_d == '0);
  assign less_d = (ALUOp == OP_CMP) ? cmp : signed_lt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        less_q   <= less_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Less      = less_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table plus random ops, scoreboarded through an
// expected queue, with hand sequences for hold, async reset and restart.
module tb_alu;

  localparam int W = 34;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic [6:0]  f7;
    logic [31:0] res;
    logic        z;
    logic        l;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [4:0]  shamt;
  logic [6:0]  funct7;
  logic        out_valid;
  logic [31:0] Result;
  logic        Zero;
  logic        Less;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           errors;
  logic [W-1:0] last_exp;

  alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .ALUOp(ALUOp), .funct3(funct3), .shamt(shamt), .funct7(funct7),
    .out_valid(out_valid), .Result(Result), .Zero(Zero), .Less(Less)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // independent reference for random stimulus
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op, input logic [2:0] f3,
                                         input logic [4:0] sh, input logic [6:0] f7);
    logic [31:0] r;
    logic        c;
    logic        slt;
    slt = (a[31] != b[31]) ? a[31] : (a < b);
    r = 32'h0;
    c = 1'b0;
    case (op)
      2'd0: r = f7[5] ? (a + ~b + 32'd1) : (a + b);
      2'd1: begin
        if (f3 == 3'd0) r = a & b;
        else if (f3 == 3'd1) r = a | b;
        else if (f3 == 3'd2) r = a ^ b;
      end
      2'd2: begin
        if (f3 == 3'd0) r = a << sh;
        else if (f3 == 3'd5 && !f7[5]) r = a >> sh;
        else if (f3 == 3'd5) r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      end
      default: begin
        if (f3 == 3'd2) c = slt;
        else if (f3 == 3'd3) c = (a < b);
        r = {31'b0, c};
      end
    endcase
    return {r, (r == 32'h0), (op == 2'd3) ? c : slt};
  endfunction

  // driver: call right after a falling edge
  task automatic drive(input vec_t v, input string tag);
    in_valid = 1'b1;
    A      = v.a;
    B      = v.b;
    ALUOp  = v.op;
    funct3 = v.f3;
    funct7 = v.f7;
    shamt  = (v.op == 2'b10) ? v.sh : 5'($urandom_range(0, 31));
    exp_q.push_back({v.res, v.z, v.l});
    tag_q.push_back(tag);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (no op pending)");
      end else begin
        logic [W-1:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        last_exp = e;
        if ({Result, Zero, Less} !== e) begin
          errors++;
          $display("FAIL %s: got result=%h zero=%b less=%b, expected result=%h zero=%b less=%b",
                   t, Result, Zero, Less, e[33:2], e[1], e[0]);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                              input logic [2:0] f3, input logic [4:0] sh, input logic [6:0] f7,
                              input logic [31:0] res, input logic z, input logic l);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.f3 = f3; v.sh = sh; v.f7 = f7;
    v.res = res; v.z = z; v.l = l;
    return v;
  endfunction

  localparam int NV = 25;
  vec_t vecs[NV];

  initial begin
    checks = 0;
    errors = 0;
    last_exp = '0;

    vecs[0]  = mk(32'h0000000A, 32'h00000014, 2'b00, 3'b000, 5'd0,  7'h00, 32'h0000001E, 0, 1);
    vecs[1]  = mk(32'h00000014, 32'h0000000A, 2'b00, 3'b000, 5'd0,  7'h20, 32'h0000000A, 0, 0);
    vecs[2]  = mk(32'h0F0F0F0F, 32'h00FF00FF, 2'b01, 3'b000, 5'd0,  7'h00, 32'h000F000F, 0, 0);
    vecs[3]  = mk(32'h0F0F0F0F, 32'h00FF00FF, 2'b01, 3'b001, 5'd0,  7'h00, 32'h0FFF0FFF, 0, 0);
    vecs[4]  = mk(32'h0F0F0F0F, 32'h00FF00FF, 2'b01, 3'b010, 5'd0,  7'h00, 32'h0FF00FF0, 0, 0);
    vecs[5]  = mk(32'h0F0F0F0F, 32'h00FF00FF, 2'b01, 3'b011, 5'd0,  7'h00, 32'h00000000, 1, 0);
    vecs[6]  = mk(32'h00000001, 32'h00000000, 2'b10, 3'b000, 5'd5,  7'h00, 32'h00000020, 0, 0);
    vecs[7]  = mk(32'h00000020, 32'h00000000, 2'b10, 3'b101, 5'd2,  7'h00, 32'h00000008, 0, 0);
    vecs[8]  = mk(32'hFFFFFFE0, 32'h00000000, 2'b10, 3'b101, 5'd2,  7'h20, 32'hFFFFFFF8, 0, 1);
    vecs[9]  = mk(32'h80000000, 32'h00000000, 2'b10, 3'b101, 5'd31, 7'h20, 32'hFFFFFFFF, 0, 1);
    vecs[10] = mk(32'h80000000, 32'h00000000, 2'b10, 3'b101, 5'd31, 7'h00, 32'h00000001, 0, 1);
    vecs[11] = mk(32'h12345678, 32'h00000000, 2'b10, 3'b000, 5'd0,  7'h00, 32'h12345678, 0, 0);
    vecs[12] = mk(32'h00000005, 32'h00000000, 2'b10, 3'b001, 5'd3,  7'h00, 32'h00000000, 1, 0);
    vecs[13] = mk(32'h00000001, 32'h00000002, 2'b11, 3'b010, 5'd0,  7'h00, 32'h00000001, 0, 1);
    vecs[14] = mk(32'hFFFFFFFE, 32'h00000001, 2'b11, 3'b011, 5'd0,  7'h00, 32'h00000000, 1, 0);
    vecs[15] = mk(32'hFFFFFFFE, 32'h00000001, 2'b11, 3'b010, 5'd0,  7'h00, 32'h00000001, 0, 1);
    vecs[16] = mk(32'h00000001, 32'hFFFFFFFE, 2'b11, 3'b011, 5'd0,  7'h00, 32'h00000001, 0, 1);
    vecs[17] = mk(32'h00000001, 32'h00000002, 2'b11, 3'b000, 5'd0,  7'h00, 32'h00000000, 1, 0);
    vecs[18] = mk(32'h00000000, 32'h00000000, 2'b00, 3'b000, 5'd0,  7'h00, 32'h00000000, 1, 0);
    vecs[19] = mk(32'hFFFFFFFF, 32'h00000001, 2'b00, 3'b000, 5'd0,  7'h00, 32'h00000000, 1, 1);
    vecs[20] = mk(32'h00000000, 32'h00000001, 2'b00, 3'b000, 5'd0,  7'h20, 32'hFFFFFFFF, 0, 1);
    vecs[21] = mk(32'h00000003, 32'h00000004, 2'b00, 3'b111, 5'd0,  7'h00, 32'h00000007, 0, 1);
    vecs[22] = mk(32'h7FFFFFFF, 32'h80000000, 2'b11, 3'b010, 5'd0,  7'h00, 32'h00000000, 1, 0);
    vecs[23] = mk(32'h80000001, 32'h00000000, 2'b10, 3'b101, 5'd1,  7'h20, 32'hC0000000, 0, 1);
    vecs[24] = mk(32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 3'b000, 5'd0,  7'h20, 32'h00000000, 1, 0);

    rst_n = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; ALUOp = '0; funct3 = '0; shamt = '0; funct7 = '0;
    #12;
    check1("reset_result",    Result,           32'h0);
    check1("reset_zero",      {31'b0, Zero},    32'h0);
    check1("reset_less",      {31'b0, Less},    32'h0);
    check1("reset_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i], $sformatf("vec%0d", i));
    end

    // back-to-back random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      logic [W-1:0] e;
      v.a  = $urandom; v.b = $urandom;
      v.op = 2'($urandom_range(0, 3));
      v.f3 = 3'($urandom_range(0, 7));
      if (v.op == 2'b10 && $urandom_range(0, 1) == 1) v.f3 = 3'b101;
      if (v.op == 2'b11 && $urandom_range(0, 1) == 1) v.f3 = 3'($urandom_range(2, 3));
      v.sh = 5'($urandom_range(0, 31));
      v.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      e = model(v.a, v.b, v.op, v.f3, v.sh, v.f7);
      v.res = e[33:2]; v.z = e[1]; v.l = e[0];
      @(negedge clk);
      drive(v, $sformatf("rand%0d", i));
    end

    // idle with scrambled inputs: outputs must hold, out_valid low
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUOp = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    check1("hold_out_valid", {31'b0, out_valid}, 32'h0);
    check1("hold_result",    Result,             last_exp[33:2]);
    check1("hold_zero",      {31'b0, Zero},      {31'b0, last_exp[1]});
    check1("hold_less",      {31'b0, Less},      {31'b0, last_exp[0]});
    check1("queue_drained",  exp_q.size(),       32'h0);

    // async reset mid-stream, just after a result became valid
    @(negedge clk);
    drive(vecs[3], "pre_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check1("midreset_result",    Result,             32'h0);
    check1("midreset_zero",      {31'b0, Zero},      32'h0);
    check1("midreset_less",      {31'b0, Less},      32'h0);
    check1("midreset_out_valid", {31'b0, out_valid}, 32'h0);
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first op after release
    @(negedge clk);
    drive(vecs[8], "after_reset");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check1("after_reset_drained", exp_q.size(), 32'h0);
    check1("after_reset_idle",    {31'b0, out_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
